tetris_piece_engine: RTL and testbench
======================================

// Module: tetris_piece_engine
// PURPOSE
//  Tetris piece engine: the piece randomiser, active-piece shape/rotation manager and completed-line remover in one block.
//  Sits between gameLogic (row_in/col_in/update/firstgen/newgen) and color_mapper (cleared board).
//  Board is ROWS x COLS, row 0 at top; board column c is bit (COLS-1-c).
//  Shape is a 4x4 bitmap: shape[r][3-c] is piece cell (r,c); it maps to board (row_in+r, col_in+c).
// PARAMETERS
//  ROWS        22        board rows
//  COLS        12        board columns (bits per row)
//  SEED        16'hACE1  LFSR reset value, must be non-zero
//  KEY_ROTATE  8'h1A     HID keycode ('W') that requests clockwise rotation
// PORTS
//  clk               in   1            single clock; all state on posedge clk
//  reset             in   1            asynchronous, active-high
//  keycode           in   8            current HID keycode, 0 = no key
//  firstgen          in   1            pulse: load first piece after reset
//  newgen            in   1            pulse: previous piece locked, load next piece
//  update            in   1            game tick; rotation may commit only when 1
//  row_in            in   5            active piece reference row
//  col_in            in   4            active piece reference column
//  prev_row_contents in   [ROWS][COLS] locked board without active piece (collision source)
//  in_row_contents   in   [ROWS][COLS] board with active piece merged
//  shape             out  [4][4]       active piece bitmap
//  piece_type        out  3            active piece 0..6
//  next_type         out  3            preview piece 0..6
//  random            out  3            current random value 0..6
//  row_contents      out  [ROWS][COLS] board after full-line removal
//  lines_cleared     out  5            full rows removed in last cycle
// BEHAVIOUR
//  Reset: all outputs 0, rot=0, lfsr=SEED, rotate-key edge detector cleared.
//  Randomiser:
//   - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, advances every clk.
//   - random <= lfsr[2:0] when lfsr[2:0]!=7, else holds.
//  Piece types 0..6 = I,O,T,S,Z,J,L. Rotation-0 rows r0..r3:
//   I: 0000,1111,0000,0000   O: 0000,0110,0110,0000   T: 0100,1110,0000,0000
//   S: 0110,1100,0000,0000   Z: 1100,0110,0000,0000
//   J: 1000,1110,0000,0000   L: 0010,1110,0000,0000
//  Clockwise rotation:
//   - I: new[r][c]=old[3-c][r] over 4x4.
//   - O: unchanged.
//   - Others: new[r][c]=old[2-c][r] over r,c in 0..2; row 3 and col 3 stay 0.
//  Load:
//   - firstgen=1: piece_type<=random, next_type<=lfsr[5:3] mod 7, rot<=0.
//   - newgen=1: piece_type<=next_type, next_type<=random, rot<=0.
//   - shape becomes the rotation-0 bitmap one clk after firstgen/newgen.
//   - firstgen wins if both are asserted.
//  Rotate:
//   - Rising edge of (keycode==KEY_ROTATE) sets a pending flag; a held key gives exactly one rotation.
//   - On a clk with update=1 and pending=1, the rotated bitmap is tested; the flag clears either way.
//   - Rotation commits only if every set cell has row_in+r<ROWS, col_in+c<COLS and no overlap with prev_row_contents.
//   - Commit: rot<=rot+1 (wraps 3->0) and shape updates next clk. Otherwise shape is unchanged.
//   - A load in the same clk discards the pending rotation.
//  Line clear (registered, 1 clk latency):
//   - Every row of in_row_contents equal to all-ones is removed.
//   - Surviving rows keep their order and pack to the bottom (row ROWS-1); vacated top rows are 0.
//   - Multiple and non-adjacent full rows are removed in the same clk.
//   - lines_cleared = count of removed rows; otherwise row_contents = in_row_contents delayed 1 clk.
// STRUCTURE
//  Package tetris_pkg: ROWS, COLS, piece_t enum (I..L), shape_t (logic [3:0] [4]), board_t, KEY_ROTATE, SHAPE_ROM (rotation-0 table).
//  Sub-module tetris_line_clear (clk, reset, in_row_contents -> row_contents, lines_cleared).
//  LFSR, rotation and collision logic stay in the top.
// TESTING
//  1. Reset: 10 clk -> shape all 0, row_contents all 0, lfsr==16'hACE1; random never 7 over 1000 clk.
//  2. firstgen with random=2 -> next clk shape={0100,1110,0000,0000}, piece_type=2.
//  3. T at row_in=5, col_in=4, empty board; keycode 0x1A held 24 clk, update=1 -> exactly one rotation, shape={0100,0110,0100,0000}.
//  4. I at col_in=10, rot=1 (vertical), rotate with update=1 -> rejected (out of columns), shape unchanged.
//  5. Rows 21 and 19 = 12'hFFF, row 20=12'h801, row 18=12'h003 -> next clk row21=12'h801, row20=12'h003, rows 0..19=0, lines_cleared=2.
//  6. newgen with next_type=4 -> piece_type=4, rot=0, next_type=prior random value.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared board geometry, piece encoding and rotation-0 shape table.
package tetris_pkg;

    localparam int unsigned ROWS       = 22;
    localparam int unsigned COLS       = 12;
    localparam logic [7:0]  KEY_ROTATE = 8'h1A;

    typedef enum logic [2:0] {
        PieceI, PieceO, PieceT, PieceS, PieceZ, PieceJ, PieceL
    } piece_t;

    // shape[r] is row r (r0 is the most significant nibble); column c is bit 3-c.
    typedef logic [0:3][3:0] shape_t;
    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    localparam shape_t SHAPE_ROM [7] = '{
        16'h0F00,   // I
        16'h0660,   // O
        16'h4E00,   // T
        16'h6C00,   // S
        16'hC600,   // Z
        16'h8E00,   // J
        16'h2E00    // L
    };

    function automatic shape_t shape_rom(logic [2:0] t);
        return (t < 3'd7) ? SHAPE_ROM[t] : '0;
    endfunction

    function automatic logic [2:0] mod7(logic [2:0] v);
        return (v == 3'd7) ? 3'd0 : v;
    endfunction

endpackage

// File: rtl/tetris_line_clear.sv
// Registered full-row removal: surviving rows pack to the bottom, vacated top rows read 0.
module tetris_line_clear import tetris_pkg::*; #(
    parameter int unsigned ROWS = tetris_pkg::ROWS,
    parameter int unsigned COLS = tetris_pkg::COLS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [ROWS-1:0][COLS-1:0]  in_row_contents,
    output logic [ROWS-1:0][COLS-1:0]  row_contents,
    output logic [4:0]                 lines_cleared
);

    logic [ROWS-1:0][COLS-1:0] rows_q, rows_d;
    logic [4:0]                lines_q, lines_d;

    // Walk bottom-up, copying non-full rows to the next free slot from the bottom.
    always_comb begin : p_pack
        int dst;
        int cnt;
        rows_d = '0;
        dst    = int'(ROWS) - 1;
        cnt    = 0;
        for (int src = int'(ROWS) - 1; src >= 0; src--) begin
            if (&in_row_contents[src]) begin
                cnt++;
            end else begin
                rows_d[dst] = in_row_contents[src];
                dst--;
            end
        end
        lines_d = 5'(cnt);
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rows_q  <= '0;
            lines_q <= '0;
        end else begin
            rows_q  <= rows_d;
            lines_q <= lines_d;
        end
    end

    assign row_contents  = rows_q;
    assign lines_cleared = lines_q;

endmodule

// File: rtl/tetris_piece_engine.sv
// Piece randomiser, active-piece load/rotation with collision check, and line remover.
module tetris_piece_engine import tetris_pkg::*; #(
    parameter int unsigned ROWS       = tetris_pkg::ROWS,
    parameter int unsigned COLS       = tetris_pkg::COLS,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic [7:0]  KEY_ROTATE = tetris_pkg::KEY_ROTATE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 keycode,
    input  logic                       firstgen,
    input  logic                       newgen,
    input  logic                       update,
    input  logic [4:0]                 row_in,
    input  logic [3:0]                 col_in,
    input  logic [ROWS-1:0][COLS-1:0]  prev_row_contents,
    input  logic [ROWS-1:0][COLS-1:0]  in_row_contents,
    output shape_t                     shape,
    output logic [2:0]                 piece_type,
    output logic [2:0]                 next_type,
    output logic [2:0]                 random,
    output logic [ROWS-1:0][COLS-1:0]  row_contents,
    output logic [4:0]                 lines_cleared
);

    logic [15:0] lfsr_q, lfsr_d;
    logic [2:0]  random_q, random_d;
    logic [2:0]  piece_type_q, piece_type_d;
    logic [2:0]  next_type_q, next_type_d;
    shape_t      shape_q, shape_d;
    logic [1:0]  rot_q, rot_d;
    logic        key_q, key_d;
    logic        pending_q, pending_d;

    shape_t      rot_shape;
    logic        rot_ok;
    logic        key_rise;

    // I spins over the full 4x4, O is symmetric, the rest spin inside the top-left 3x3.
    function automatic shape_t rotate_cw(shape_t s, logic [2:0] t);
        shape_t n;
        n = '0;
        if (t == PieceO) begin
            n = s;
        end else if (t == PieceI) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    n[r][3-c] = s[3-c][3-r];
        end else begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    n[r][3-c] = s[2-c][3-r];
        end
        return n;
    endfunction

    // True when every set cell lands inside the board and on an empty locked cell.
    function automatic logic fits(shape_t s, logic [4:0] row, logic [3:0] col,
                                  logic [ROWS-1:0][COLS-1:0] board);
        int unsigned br;
        int unsigned bc;
        logic        ok;
        ok = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (s[r][3-c]) begin
                    br = int'(row) + r;
                    bc = int'(col) + c;
                    if (br >= ROWS || bc >= COLS) ok = 1'b0;
                    else if (board[br][COLS-1-bc]) ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    assign rot_shape = rotate_cw(shape_q, piece_type_q);
    assign rot_ok    = fits(rot_shape, row_in, col_in, prev_row_contents);

    // Next-state: LFSR/randomiser always run; load beats rotation; key edge arms rotation.
    always_comb begin
        lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        random_d     = (lfsr_q[2:0] != 3'd7) ? lfsr_q[2:0] : random_q;
        key_d        = (keycode == KEY_ROTATE);
        key_rise     = key_d & ~key_q;
        piece_type_d = piece_type_q;
        next_type_d  = next_type_q;
        shape_d      = shape_q;
        rot_d        = rot_q;
        pending_d    = pending_q | key_rise;

        if (firstgen || newgen) begin
            if (firstgen) begin
                piece_type_d = random_q;
                next_type_d  = mod7(lfsr_q[5:3]);
            end else begin
                piece_type_d = next_type_q;
                next_type_d  = random_q;
            end
            shape_d   = shape_rom(piece_type_d);
            rot_d     = 2'd0;
            pending_d = 1'b0;
        end else if (update && pending_q) begin
            // A request is consumed whether or not it commits.
            pending_d = key_rise;
            if (rot_ok) begin
                shape_d = rot_shape;
                rot_d   = rot_q + 2'd1;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q       <= SEED;
            random_q     <= '0;
            piece_type_q <= '0;
            next_type_q  <= '0;
            shape_q      <= '0;
            rot_q        <= '0;
            key_q        <= 1'b0;
            pending_q    <= 1'b0;
        end else begin
            lfsr_q       <= lfsr_d;
            random_q     <= random_d;
            piece_type_q <= piece_type_d;
            next_type_q  <= next_type_d;
            shape_q      <= shape_d;
            rot_q        <= rot_d;
            key_q        <= key_d;
            pending_q    <= pending_d;
        end
    end

    tetris_line_clear #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_line_clear (
        .clk             (clk),
        .reset           (reset),
        .in_row_contents (in_row_contents),
        .row_contents    (row_contents),
        .lines_cleared   (lines_cleared)
    );

    assign shape      = shape_q;
    assign piece_type = piece_type_q;
    assign next_type  = next_type_q;
    assign random     = random_q;

endmodule

// File: tb/tb_tetris_piece_engine.sv
// Scoreboard bench: expectations are queued with the stimulus and checked after the clock edge.
module tb_tetris_piece_engine;
    import tetris_pkg::*;

    localparam int R = 22;
    localparam int C = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        keycode;
    logic              firstgen, newgen, update;
    logic [4:0]        row_in;
    logic [3:0]        col_in;
    logic [R-1:0][C-1:0] prev_row_contents, in_row_contents;
    shape_t            shape;
    logic [2:0]        piece_type, next_type, random;
    logic [R-1:0][C-1:0] row_contents;
    logic [4:0]        lines_cleared;

    tetris_piece_engine dut (
        .clk               (clk),
        .reset             (reset),
        .keycode           (keycode),
        .firstgen          (firstgen),
        .newgen            (newgen),
        .update            (update),
        .row_in            (row_in),
        .col_in            (col_in),
        .prev_row_contents (prev_row_contents),
        .in_row_contents   (in_row_contents),
        .shape             (shape),
        .piece_type        (piece_type),
        .next_type         (next_type),
        .random            (random),
        .row_contents      (row_contents),
        .lines_cleared     (lines_cleared)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          tag;
        int             sel;
        logic [319:0]   val;
    } exp_t;

    localparam int SelShape = 0, SelPiece = 1, SelNext = 2, SelRows = 3, SelLines = 4;

    exp_t        sb[$];
    int          n_run = 0;
    int          n_fail = 0;
    logic [15:0] m_lfsr;
    logic [2:0]  m_rnd, m_next;

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [319:0] observed(int sel);
        case (sel)
            SelShape: return 320'(shape);
            SelPiece: return 320'(piece_type);
            SelNext:  return 320'(next_type);
            SelRows:  return 320'(row_contents);
            default:  return 320'(lines_cleared);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [319:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] lfsr_step(logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Reference line removal: keep non-full rows in order, stacked at the bottom.
    function automatic logic [R-1:0][C-1:0] clear_model(logic [R-1:0][C-1:0] b, output int n);
        logic [R-1:0][C-1:0] o;
        int                  d;
        o = '0;
        d = R - 1;
        n = 0;
        for (int s = R - 1; s >= 0; s--) begin
            if (b[s] == {C{1'b1}}) n++;
            else begin
                o[d] = b[s];
                d--;
            end
        end
        return o;
    endfunction

    // One clock: advance the randomiser model, then check random and drain the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        if (!reset) begin
            if (m_lfsr[2:0] != 3'd7) m_rnd = m_lfsr[2:0];
            m_lfsr = lfsr_step(m_lfsr);
        end
        #1;
        check_eq("random", 320'(random), 320'(m_rnd));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observed(e.sel), e.val);
        end
    endtask

    task automatic wait_rnd(input logic [2:0] v);
        for (int i = 0; i < 400 && m_rnd != v; i++) tick();
        check_eq("wait_random", 320'(random), 320'(v));
    endtask

    initial begin
        logic [R-1:0][C-1:0] b, exp_b;
        int                  n;

        reset = 1'b1; keycode = '0; firstgen = 0; newgen = 0; update = 0;
        row_in = 5'd5; col_in = 4'd4; prev_row_contents = '0; in_row_contents = '0;
        m_lfsr = 16'hACE1; m_rnd = '0; m_next = '0;

        // Reset state
        repeat (9) tick();
        push("rst_shape", SelShape, '0);
        push("rst_piece", SelPiece, '0);
        push("rst_next", SelNext, '0);
        push("rst_rows", SelRows, '0);
        push("rst_lines", SelLines, '0);
        tick();
        check_eq("rst_lfsr", 320'(dut.lfsr_q), 320'(16'hACE1));
        reset = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            check_eq("random_not7", 320'(random == 3'd7), '0);
        end

        // First piece: T
        wait_rnd(3'd2);
        firstgen = 1'b1;
        push("fg_piece", SelPiece, 320'(3'd2));
        push("fg_next", SelNext, 320'(mod7(m_lfsr[5:3])));
        push("fg_shape", SelShape, 320'(16'h4E00));
        tick();
        firstgen = 1'b0;

        // Held rotate key with update=1 rotates exactly once
        update = 1'b1; keycode = 8'h1A;
        repeat (23) tick();
        push("rot_once", SelShape, 320'(16'h4640));
        tick();
        keycode = 8'h00;
        tick();

        // Armed while update=0, then blocked by a locked cell at (7,5)
        update = 1'b0; keycode = 8'h1A;
        repeat (3) tick();
        update = 1'b1; prev_row_contents[7] = 12'h040;
        push("rot_blocked", SelShape, 320'(16'h4640));
        tick();
        push("rot_blocked_hold", SelShape, 320'(16'h4640));
        tick();
        keycode = 8'h00; prev_row_contents = '0;
        tick();
        keycode = 8'h1A;
        tick();
        push("rot_free", SelShape, 320'(16'h0E40));
        tick();
        keycode = 8'h00;

        // I piece: vertical at col 4, then rejected at col 10
        wait_rnd(3'd0);
        firstgen = 1'b1;
        m_next = mod7(m_lfsr[5:3]);
        push("i_piece", SelPiece, '0);
        push("i_shape", SelShape, 320'(16'h0F00));
        tick();
        firstgen = 1'b0; keycode = 8'h1A;
        tick();
        push("i_vertical", SelShape, 320'(16'h2222));
        tick();
        keycode = 8'h00; col_in = 4'd10;
        tick();
        keycode = 8'h1A;
        tick();
        push("i_edge_reject", SelShape, 320'(16'h2222));
        tick();
        keycode = 8'h00; col_in = 4'd4;

        // newgen promotes next_type; both pulses together favour firstgen
        wait_rnd(3'd4);
        newgen = 1'b1;
        push("ng1_piece", SelPiece, 320'(m_next));
        push("ng1_next", SelNext, 320'(3'd4));
        m_next = m_rnd;
        tick();
        push("ng2_piece", SelPiece, 320'(3'd4));
        push("ng2_next", SelNext, 320'(m_rnd));
        push("ng2_shape", SelShape, 320'(16'hC600));
        tick();
        firstgen = 1'b1;
        push("both_piece", SelPiece, 320'(m_rnd));
        push("both_next", SelNext, 320'(mod7(m_lfsr[5:3])));
        push("both_shape", SelShape, 320'(SHAPE_ROM[m_rnd]));
        tick();
        firstgen = 1'b0; newgen = 1'b0; update = 1'b0;

        // Line clear: two non-adjacent full rows at the bottom
        b = '0;
        b[21] = 12'hFFF; b[20] = 12'h801; b[19] = 12'hFFF; b[18] = 12'h003;
        in_row_contents = b;
        exp_b = '0; exp_b[21] = 12'h801; exp_b[20] = 12'h003;
        push("lc_rows", SelRows, 320'(exp_b));
        push("lc_lines", SelLines, 320'(5'd2));
        tick();

        // All rows full -> empty board
        in_row_contents = '1;
        push("lc_all_rows", SelRows, '0);
        push("lc_all_lines", SelLines, 320'(5'd22));
        tick();

        // Top row full only
        b = '0; b[0] = 12'hFFF; b[1] = 12'h5A5; b[21] = 12'h00F;
        exp_b = '0; exp_b[21] = 12'h00F; exp_b[1] = 12'h5A5;
        in_row_contents = b;
        push("lc_top_rows", SelRows, 320'(exp_b));
        push("lc_top_lines", SelLines, 320'(5'd1));
        tick();

        // Random boards, back to back
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < R; r++) begin
                if ($urandom_range(3) == 0) b[r] = 12'hFFF;
                else b[r] = 12'($urandom_range(12'hFFE));
            end
            in_row_contents = b;
            exp_b = clear_model(b, n);
            push("lc_rand_rows", SelRows, 320'(exp_b));
            push("lc_rand_lines", SelLines, 320'(n));
            tick();
        end

        // No full row -> plain one-clock delay
        in_row_contents = b & {R{12'h7FF}};
        push("lc_none_rows", SelRows, 320'(b & {R{12'h7FF}}));
        push("lc_none_lines", SelLines, '0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
